// File: rtl/genius_seq_player.sv
// Genius sequence presenter: plays ROM entries 0..limit on the LEDs,
// each lit for ON_CYCLES and followed by an OFF_CYCLES blank gap.
module genius_seq_player #(
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] limit,
    input  logic [3:0] rom_data,
    output logic [3:0] rom_addr,
    output logic [3:0] leds,
    output logic       busy,
    output logic       done,
    output logic [2:0] db_state
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | one cycle covering the ROM read latency
    // SHOW   | entry lit for ON_CYCLES
    // GAP    | LEDs blank for OFF_CYCLES
    // DONE   | single-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    lim_q, lim_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            lim_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_FETCH;
                        idx_d   = '0;
                        lim_d   = limit;
                    end
                end
                S_FETCH: begin
                    cnt_d   = '0;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt_q == ON_LAST) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == OFF_LAST) begin
                        cnt_d = '0;
                        // index holds at the last entry; it never wraps
                        if (idx_q == lim_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rom_addr = idx_q;
        db_state = state_q;
        leds     = (state_q == S_SHOW) ? rom_data : 4'd0;
        busy     = (state_q == S_FETCH) || (state_q == S_SHOW) || (state_q == S_GAP);
        done     = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_genius_seq_player.sv
// Randomised bench for genius_seq_player against a cycle-arithmetic model
// of the playback timeline (FETCH at 1+k*P, SHOW, GAP, DONE at 1+(L+1)*P).
module tb_genius_seq_player;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = 1 + ON + OFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [3:0] limit = 4'd0;
    logic [3:0] rom_data = 4'd0;
    logic [3:0] rom_addr;
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [2:0] db_state;

    logic [3:0] rom [16];
    int n_chk  = 0;
    int n_pass = 0;
    int cur_c  = 0;

    genius_seq_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .limit    (limit),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .leds     (leds),
        .busy     (busy),
        .done     (done),
        .db_state (db_state)
    );

    always #5 clock = ~clock;

    // synchronous ROM, one-cycle read latency
    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cur_c, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input int st, input int addr, input int led);
        check("db_state", int'(db_state), st);
        check("rom_addr", int'(rom_addr), addr);
        check("leds", int'(leds), led);
        check("busy", int'(busy), (st >= 1 && st <= 3) ? 1 : 0);
        check("done", int'(done), (st == 4) ? 1 : 0);
    endtask

    // Expected view of cycle t of a run started at cycle 0 with limit L.
    task automatic model(input int t, input int L, output int st, output int addr,
                         output int led);
        int d, k, r;
        d   = 1 + (L + 1) * P;
        led = 0;
        if (t > d) begin
            st = 0; addr = L;
        end else if (t == d) begin
            st = 4; addr = L;
        end else begin
            k = (t - 1) / P;
            r = (t - 1) % P;
            addr = k;
            if (r == 0) st = 1;
            else if (r <= ON) begin
                st = 2; led = int'(rom[k]);
            end else st = 3;
        end
    endtask

    // One playback. stop_c/start_c/lim_c/rst_c < 0 disable that disturbance.
    task automatic run_seq(input int L, input int stop_c, input int start_c,
                           input int lim_c, input int lim_v, input int rst_c);
        int c, end_c, st, addr, led;
        c = 0;
        cur_c = 0;
        start = 1'b1;
        stop  = 1'b0;
        limit = 4'(L);
        end_c = (stop_c >= 0) ? stop_c + 1 : 2 + (L + 1) * P;
        while (c < end_c) begin
            tick();
            c++;
            cur_c = c;
            model(c, L, st, addr, led);
            if (stop_c >= 0 && c > stop_c) begin
                st = 0; addr = 0; led = 0;
            end
            check_outputs(st, addr, led);
            if (c == rst_c) begin
                #1 reset = 1'b1;
                #1 check_outputs(0, 0, 0);
                tick();
                cur_c = c + 1;
                check_outputs(0, 0, 0);
                reset = 1'b0;
                tick();
                cur_c = c + 2;
                check_outputs(0, 0, 0);
                start = 1'b0;
                return;
            end
            start = (c == start_c);
            stop  = (c == stop_c);
            if (c == lim_c) limit = 4'(lim_v);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic load_rom_random();
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << $urandom_range(0, 3));
    endtask

    initial begin
        int L, gs, lc;
        load_rom_random();

        // reset state
        tick();
        cur_c = 0;
        check_outputs(0, 0, 0);
        reset = 1'b0;
        tick();
        check_outputs(0, 0, 0);

        // single entry
        rom[0] = 4'b0001;
        run_seq(0, -1, -1, -1, 0, -1);

        // four entries, immediately re-accepted after the previous DONE
        rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b0010; rom[3] = 4'b1000;
        run_seq(3, -1, -1, -1, 0, -1);

        // full sequence: index parks at 15 until the next start
        load_rom_random();
        run_seq(15, -1, -1, -1, 0, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("park_addr", int'(rom_addr), 15);
            check("park_done", int'(done), 0);
        end

        // abort in cycle 10, restart in cycle 11
        rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b0010; rom[3] = 4'b1000;
        run_seq(3, 10, -1, -1, 0, -1);
        run_seq(3, -1, -1, -1, 0, -1);

        // start re-pulsed and limit changed mid-run are ignored
        run_seq(2, -1, 4, 3, 0, -1);

        // start together with stop in IDLE stays in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        check("start_stop_state", int'(db_state), 0);
        check("start_stop_busy", int'(busy), 0);
        start = 1'b0; stop = 1'b0;
        tick();

        // async reset mid-SHOW of entry 1 (cycle 9)
        rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b0010; rom[3] = 4'b1000;
        run_seq(3, -1, -1, -1, 0, 9);

        // randomised runs with ignored start pulses and limit changes
        for (int n = 0; n < 6; n++) begin
            load_rom_random();
            L  = $urandom_range(0, 5);
            gs = $urandom_range(1, 1 + (L + 1) * P);
            lc = $urandom_range(1, 1 + (L + 1) * P);
            run_seq(L, -1, gs, lc, $urandom_range(0, 15), -1);
        end

        // randomised abort point
        load_rom_random();
        L = $urandom_range(1, 4);
        run_seq(L, $urandom_range(1, (L + 1) * P), -1, -1, 0, -1);
        run_seq(1, -1, -1, -1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
